// File: rtl/ps2_keycode_receiver_pkg.sv
// Key codes and PS/2 prefix bytes shared with the minesweeper processor datapath,
// plus the frame-receiver state encoding.
package minesweeper_keys;

  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_F     = 8'h2B;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic parityOk(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, start/data/parity/stop FSM and a
// mid-frame timeout. Outputs are combinational pulses on the stop-bit fall cycle.
module ps2_frame_rx
  import minesweeper_keys::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] rxByte,
  output logic       byteValid,
  output logic       err,
  output logic       timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clkSync;
  logic [1:0]    dataSync;
  logic          clkPrev;
  logic          fall;
  logic          sData;
  logic [1:0]    state;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg;
  logic          parityBit;
  logic [CW-1:0] toCnt;
  logic          timeoutHit;
  logic          stopFall;
  logic          frameGood;

  assign sData      = dataSync[1];
  assign fall       = clkPrev & ~clkSync[1];
  // A fall restarts the counter, so a timeout never coincides with a sampled bit.
  assign timeoutHit = (state != ST_IDLE) && !fall && (toCnt == TO_LAST);
  assign stopFall   = fall && (state == ST_STOP);
  assign frameGood  = sData && parityOk(shiftReg, parityBit);

  assign rxByte    = shiftReg;
  assign byteValid = stopFall && frameGood;
  assign err       = (stopFall && !frameGood) || timeoutHit;
  assign timeout   = timeoutHit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clkSync  <= 2'b11;
      dataSync <= 2'b11;
      clkPrev  <= 1'b1;
    end else begin
      clkSync  <= {clkSync[0], ps2Clk};
      dataSync <= {dataSync[0], ps2Data};
      clkPrev  <= clkSync[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      bitCnt    <= 3'd0;
      shiftReg  <= 8'h00;
      parityBit <= 1'b0;
      toCnt     <= '0;
    end else if (timeoutHit) begin
      state <= ST_IDLE;
      toCnt <= '0;
    end else begin
      if (fall) begin
        toCnt <= '0;
      end else if (state != ST_IDLE) begin
        toCnt <= toCnt + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (fall && !sData) begin
            state  <= ST_DATA;
            bitCnt <= 3'd0;
          end
        end
        ST_DATA: begin
          if (fall) begin
            shiftReg <= {sData, shiftReg[7:1]};
            bitCnt   <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
              state <= ST_PARITY;
            end
          end
        end
        ST_PARITY: begin
          if (fall) begin
            parityBit <= sData;
            state     <= ST_STOP;
          end
        end
        default: begin
          if (fall) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/ps2_keycode_receiver.sv
// PS/2 keyboard front end: turns raw frames into one-cycle make-code pulses,
// folding E0/F0 prefixes and optionally dropping typematic repeats.
module ps2_keycode_receiver
  import minesweeper_keys::*;
#(
  parameter int TIMEOUT_CYCLES  = 50000,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keyCode,
  output logic       keyExtended,
  output logic       frameErr
);

  logic [7:0] rxByte;
  logic       byteValid;
  logic       rxErr;
  logic       rxTimeout;
  logic       extFlag;
  logic       brkFlag;
  logic [8:0] lastMake;
  logic       isRepeat;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) frameRx (
    .clk      (clk),
    .reset    (reset),
    .ps2Clk   (ps2_clk),
    .ps2Data  (ps2_data),
    .rxByte   (rxByte),
    .byteValid(byteValid),
    .err      (rxErr),
    .timeout  (rxTimeout)
  );

  assign isRepeat = SUPPRESS_REPEAT && ({extFlag, rxByte} == lastMake);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keyCode     <= 8'h00;
      keyExtended <= 1'b0;
      frameErr    <= 1'b0;
      extFlag     <= 1'b0;
      brkFlag     <= 1'b0;
      lastMake    <= 9'h000;
    end else begin
      keyCode     <= 8'h00;
      keyExtended <= 1'b0;
      frameErr    <= rxErr;
      if (rxTimeout) begin
        extFlag <= 1'b0;
        brkFlag <= 1'b0;
      end else if (byteValid) begin
        if (rxByte == PS2_EXT) begin
          extFlag <= 1'b1;
        end else if (rxByte == PS2_BRK) begin
          brkFlag <= 1'b1;
        end else if (brkFlag) begin
          // Releasing the held key re-arms it so the next press is reported.
          brkFlag <= 1'b0;
          extFlag <= 1'b0;
          if ({extFlag, rxByte} == lastMake) begin
            lastMake <= 9'h000;
          end
        end else begin
          lastMake <= {extFlag, rxByte};
          extFlag  <= 1'b0;
          if (rxByte != 8'h00 && !isRepeat) begin
            keyCode     <= rxByte;
            keyExtended <= extFlag;
          end
        end
      end
    end
  end

endmodule
